// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package regfile_arb_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned STAT_W = 16;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of WB, mult/div, hazard and register-file write-port signals.
// master: pipeline side (drives requests); slave: the arbiter.
interface regfile_wb_arbiter_if;
  import regfile_arb_pkg::*;

  logic              wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              md_issue;
  logic [REG_AW-1:0] md_issue_addr;
  logic              md_valid;
  logic [REG_AW-1:0] md_addr;
  logic [DATA_W-1:0] md_data;
  logic              md_ready;
  logic [REG_AW-1:0] ra_1;
  logic [REG_AW-1:0] ra_2;
  logic              id_we;
  logic [REG_AW-1:0] id_wa;
  logic              stall;
  logic              wb_hold;
  logic              write_enable;
  logic [REG_AW-1:0] write_address;
  logic [DATA_W-1:0] write_data;

  modport master (
    output wb_we, wb_addr, wb_data,
    output md_issue, md_issue_addr, md_valid, md_addr, md_data,
    output ra_1, ra_2, id_we, id_wa,
    input  md_ready, stall, wb_hold,
    input  write_enable, write_address, write_data
  );

  modport slave (
    input  wb_we, wb_addr, wb_data,
    input  md_issue, md_issue_addr, md_valid, md_addr, md_data,
    input  ra_1, ra_2, id_we, id_wa,
    output md_ready, stall, wb_hold,
    output write_enable, write_address, write_data
  );

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_result_fifo: DEPTH-entry synchronous FIFO of mult/div results.
// Push while full and pop while empty are ignored; pointers wrap modulo DEPTH.
module wb_result_fifo
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  wr_req_t                      push_data,
  input  logic                         pop,
  output wr_req_t                      head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  wr_req_t         mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the WB
// stage (priority) and buffered mult/div results, with a starvation guard
// and a pending-destination scoreboard for decode hazards.
// Optional: define REGFILE_ARB_STATS_EN for stat_conflicts/stat_holds.
module regfile_wb_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]    stat_conflicts,
  output logic [STAT_W-1:0]    stat_holds
`endif
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  wr_req_t         fifo_head;
  wr_req_t         fifo_in;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            wb_grant;
  logic            fifo_grant;
  logic            wb_hold_q;
  logic [3:0]      starve_cnt;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  assign fifo_in.addr = bus.md_addr;
  assign fifo_in.data = bus.md_data;
  assign bus.md_ready = (fifo_count < CW'(DEPTH));
  assign fifo_push    = bus.md_valid && !fifo_full;
  assign wb_grant     = bus.wb_we && !wb_hold_q;
  assign fifo_grant   = !wb_grant && !fifo_empty;
  assign bus.wb_hold  = wb_hold_q;

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_grant),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Write-port mux; r0 targets are granted the cycle but never enabled.
  always_comb begin
    bus.write_enable  = 1'b0;
    bus.write_address = '0;
    bus.write_data    = '0;
    if (wb_grant) begin
      if (bus.wb_addr != '0) begin
        bus.write_enable  = 1'b1;
        bus.write_address = bus.wb_addr;
        bus.write_data    = bus.wb_data;
      end
    end else if (fifo_grant) begin
      if (fifo_head.addr != '0) begin
        bus.write_enable  = 1'b1;
        bus.write_address = fifo_head.addr;
        bus.write_data    = fifo_head.data;
      end
    end
  end

  // Scoreboard next state: commit clears, issue sets afterwards so set wins.
  always_comb begin
    pending_nxt = pending;
    if (fifo_grant) pending_nxt[fifo_head.addr] = 1'b0;
    if (bus.md_issue && (bus.md_issue_addr != '0)) pending_nxt[bus.md_issue_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign bus.stall = pending[bus.ra_1] | pending[bus.ra_2] | (bus.id_we & pending[bus.id_wa]);

  // Starvation guard: the edge that would bring the count to STARVE_LIMIT
  // raises wb_hold for the next cycle and clears the count instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      wb_hold_q  <= 1'b0;
    end else begin
      wb_hold_q <= 1'b0;
      if (fifo_empty || fifo_grant) begin
        starve_cnt <= '0;
      end else if (wb_grant) begin
        if (starve_cnt == 4'(STARVE_LIMIT - 1)) begin
          starve_cnt <= '0;
          wb_hold_q  <= 1'b1;
        end else begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  // Saturating conflict and hold counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_conflicts <= '0;
      stat_holds     <= '0;
    end else begin
      if (bus.wb_we && !fifo_empty && (stat_conflicts != '1)) stat_conflicts <= stat_conflicts + 1'b1;
      if (wb_hold_q && (stat_holds != '1))                    stat_holds     <= stat_holds + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_regfile_wb_arbiter;
  import regfile_arb_pkg::*;

  logic clk;
  logic rst_n;
  int unsigned n_cmp;
  int unsigned n_err;

  regfile_wb_arbiter_if bus ();

`ifdef REGFILE_ARB_STATS_EN
  logic [STAT_W-1:0] stat_conflicts;
  logic [STAT_W-1:0] stat_holds;
`endif

  regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef REGFILE_ARB_STATS_EN
    ,
    .stat_conflicts (stat_conflicts),
    .stat_holds     (stat_holds)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.md_issue = 1'b0; bus.md_issue_addr = '0;
    bus.md_valid = 1'b0; bus.md_addr = '0; bus.md_data = '0;
    bus.ra_1 = '0; bus.ra_2 = '0; bus.id_we = 1'b0; bus.id_wa = '0;
  endtask

  task automatic check_port(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    check_eq({tag, ".we"}, 32'(bus.write_enable), 32'(we));
    check_eq({tag, ".wa"}, 32'(bus.write_address), 32'(wa));
    check_eq({tag, ".wd"}, bus.write_data, wd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();
    #3;
    check_port("rst", 1'b0, 5'd0, 32'h0);
    check_eq("rst.md_ready", 32'(bus.md_ready), 32'd1);
    check_eq("rst.stall",    32'(bus.stall),    32'd0);
    check_eq("rst.wb_hold",  32'(bus.wb_hold),  32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // WB write with idle FIFO, same-cycle
    bus.wb_we = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hA5A5A5A5;
    #2 check_port("wb5", 1'b1, 5'd5, 32'hA5A5A5A5);
    bus.wb_addr = 5'd0;
    #1 check_port("wb_r0", 1'b0, 5'd0, 32'h0);
    tick(); idle();

    // Scoreboard RAW/WAW and release
    bus.md_issue = 1'b1; bus.md_issue_addr = 5'd9;
    tick();
    bus.md_issue = 1'b0; bus.ra_1 = 5'd9;
    #2 check_eq("raw9", 32'(bus.stall), 32'd1);
    bus.ra_1 = 5'd0; bus.id_we = 1'b1; bus.id_wa = 5'd9;
    #1 check_eq("waw9", 32'(bus.stall), 32'd1);
    bus.id_we = 1'b0;
    #1 check_eq("noid9", 32'(bus.stall), 32'd0);
    tick();
    bus.ra_1 = 5'd9; bus.md_valid = 1'b1; bus.md_addr = 5'd9; bus.md_data = 32'h1234;
    #2 check_port("md9_accept", 1'b0, 5'd0, 32'h0);
    tick();
    bus.md_valid = 1'b0;
    #2 check_port("md9_write", 1'b1, 5'd9, 32'h1234);
    check_eq("md9_stall_commit", 32'(bus.stall), 32'd1);
    tick();
    #2 check_eq("md9_stall_rel", 32'(bus.stall), 32'd0);
    check_port("md9_empty", 1'b0, 5'd0, 32'h0);
    idle();

    // r0 FIFO entry is popped without a write
    bus.md_valid = 1'b1; bus.md_addr = 5'd0; bus.md_data = 32'hFF;
    tick();
    bus.md_addr = 5'd4; bus.md_data = 32'h44;
    #2 check_port("md_r0", 1'b0, 5'd0, 32'h0);
    tick();
    bus.md_valid = 1'b0;
    #2 check_port("md4_after_r0", 1'b1, 5'd4, 32'h44);
    tick();

    // Starvation: hold in the 5th blocked cycle
    bus.wb_we = 1'b1; bus.wb_addr = 5'd10; bus.wb_data = 32'h100;
    bus.md_valid = 1'b1; bus.md_addr = 5'd3; bus.md_data = 32'h33;
    #2 check_port("starve0", 1'b1, 5'd10, 32'h100);
    tick();
    bus.md_valid = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      bus.wb_addr = 5'(10 + i); bus.wb_data = 32'h100 + i;
      #2 check_eq($sformatf("starve%0d.hold", i), 32'(bus.wb_hold), 32'd0);
      check_eq($sformatf("starve%0d.wa", i), 32'(bus.write_address), 32'(10 + i));
      tick();
    end
    bus.wb_addr = 5'd15; bus.wb_data = 32'h150;
    #2 check_eq("starve5.hold", 32'(bus.wb_hold), 32'd1);
    check_port("starve5", 1'b1, 5'd3, 32'h33);
    tick();
    #2 check_eq("starve6.hold", 32'(bus.wb_hold), 32'd0);
    check_port("starve6", 1'b1, 5'd15, 32'h150);
    tick(); idle();

    // FIFO full backpressure, held result not lost
    bus.wb_we = 1'b1; bus.wb_addr = 5'd20; bus.wb_data = 32'h20;
    bus.md_valid = 1'b1; bus.md_addr = 5'd21; bus.md_data = 32'h1;
    #2 check_eq("full_a.rdy", 32'(bus.md_ready), 32'd1);
    tick();
    bus.md_addr = 5'd22; bus.md_data = 32'h2;
    #2 check_eq("full_b.rdy", 32'(bus.md_ready), 32'd1);
    tick();
    bus.md_addr = 5'd23; bus.md_data = 32'h3;
    #2 check_eq("full_c.rdy", 32'(bus.md_ready), 32'd0);
    check_port("full_c", 1'b1, 5'd20, 32'h20);
    tick();
    bus.wb_we = 1'b0;
    #2 check_eq("full_d.rdy", 32'(bus.md_ready), 32'd0);
    check_port("full_d", 1'b1, 5'd21, 32'h1);
    tick();
    #2 check_eq("full_e.rdy", 32'(bus.md_ready), 32'd1);
    check_port("full_e", 1'b1, 5'd22, 32'h2);
    tick();
    bus.md_valid = 1'b0;
    #2 check_port("full_f", 1'b1, 5'd23, 32'h3);
    tick();
    #2 check_port("full_g", 1'b0, 5'd0, 32'h0);
    idle();

    // Same-cycle issue and commit to r7: set wins
    bus.md_issue = 1'b1; bus.md_issue_addr = 5'd7;
    tick();
    bus.md_issue = 1'b0; bus.md_valid = 1'b1; bus.md_addr = 5'd7; bus.md_data = 32'h77;
    bus.ra_1 = 5'd7;
    #2 check_eq("r7_pend", 32'(bus.stall), 32'd1);
    tick();
    bus.md_valid = 1'b0; bus.md_issue = 1'b1; bus.md_issue_addr = 5'd7;
    #2 check_port("r7_commit", 1'b1, 5'd7, 32'h77);
    tick();
    bus.md_issue = 1'b0; bus.ra_1 = 5'd0; bus.ra_2 = 5'd7;
    #2 check_eq("r7_setwins", 32'(bus.stall), 32'd1);

    // Reset mid-operation with a queued result and r7 pending
    tick();
    bus.ra_2 = 5'd0; bus.ra_1 = 5'd7;
    bus.wb_we = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'h1;
    bus.md_valid = 1'b1; bus.md_addr = 5'd8; bus.md_data = 32'h88;
    tick();
    bus.md_valid = 1'b0; bus.wb_we = 1'b0;
    #2 check_port("prerst", 1'b1, 5'd8, 32'h88);
    check_eq("prerst.stall", 32'(bus.stall), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_port("inrst", 1'b0, 5'd0, 32'h0);
    check_eq("inrst.md_ready", 32'(bus.md_ready), 32'd1);
    check_eq("inrst.stall",    32'(bus.stall),    32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    #2 check_port("postrst", 1'b0, 5'd0, 32'h0);
    check_eq("postrst.md_ready", 32'(bus.md_ready), 32'd1);
    check_eq("postrst.stall",    32'(bus.stall),    32'd0);
    check_eq("postrst.hold",     32'(bus.wb_hold),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
